// File: rtl/regfile_pkg.sv
// Shared defaults and scrub-engine state encoding for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } scrub_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, packed read ports and the scrub handshake.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     clr_start;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, rd_addr, clr_start,
    input  rd_data, clr_busy, clr_done
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, rd_addr, clr_start,
    output rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Sequential scrub engine: walks every entry once, one per cycle, then pulses clr_done.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr
);

  // DEPTH-1 is all ones, so the terminal compare stops the counter before it wraps.
  localparam logic [ADDR_W-1:0] LAST = '1;

  scrub_state_e      state;
  logic [ADDR_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign scrub_we   = clr_busy;
  assign scrub_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async read ports, two sync write ports (port 1 wins), scrub engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_start  (bus.clr_start),
    .clr_busy   (bus.clr_busy),
    .clr_done   (bus.clr_done),
    .scrub_we   (scrub_we),
    .scrub_addr (scrub_addr)
  );

  function automatic logic writable(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG == 0) || (addr != '0);
  endfunction

  // NOTE: the array is reset explicitly because a hard reset must leave every entry reading 0;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end else begin
      if (bus.wr0_en && writable(bus.wr0_addr)) mem[bus.wr0_addr] <= bus.wr0_data;
      // Issued second so port 1 overrides port 0 on an address collision.
      if (bus.wr1_en && writable(bus.wr1_addr)) mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;

    assign ra       = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);

`ifdef REGFILE_BYPASS_EN
    logic fwd0, fwd1;
    assign fwd1 = bus.wr1_en && !scrub_we && (bus.wr1_addr == ra);
    assign fwd0 = bus.wr0_en && !scrub_we && (bus.wr0_addr == ra);
    assign bus.rd_data[i*DATA_W +: DATA_W] = zero_hit ? '0           :
                                             fwd1     ? bus.wr1_data :
                                             fwd0     ? bus.wr0_data : mem[ra];
`else
    assign bus.rd_data[i*DATA_W +: DATA_W] = zero_hit ? '0 : mem[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: one ZERO_REG=1 and one ZERO_REG=0 instance on shared stimulus.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_a ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();

  assign bus_b.wr0_en    = bus_a.wr0_en;
  assign bus_b.wr0_addr  = bus_a.wr0_addr;
  assign bus_b.wr0_data  = bus_a.wr0_data;
  assign bus_b.wr1_en    = bus_a.wr1_en;
  assign bus_b.wr1_addr  = bus_a.wr1_addr;
  assign bus_b.wr1_data  = bus_a.wr1_data;
  assign bus_b.rd_addr   = bus_a.rd_addr;
  assign bus_b.clr_start = bus_a.clr_start;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut_z1 (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_dut_z0 (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // sig: 0/1 = read port of z1/z0 instance, 2/3 = busy/done z1, 4/5 = busy/done z0
  typedef struct {
    string       name;
    int          sig;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  logic chk_vld = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: plain array plus "next entry to scrub" (-1 when idle).
  logic [31:0] ref_mem [DEPTH];
  int          scrub_pos = -1;
  bit          done_m    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    scrub_pos = -1;
    done_m    = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input int addr, input bit zr);
    if (zr && addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (scrub_pos < 0) begin
      if (bus_a.wr1_en && int'(bus_a.wr1_addr) == addr) return bus_a.wr1_data;
      if (bus_a.wr0_en && int'(bus_a.wr0_addr) == addr) return bus_a.wr0_data;
    end
`endif
    return ref_mem[addr];
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit busy, start;
    if (rst) return;
    busy  = (scrub_pos >= 0);
    start = !busy && !done_m && bus_a.clr_start;
    if (busy) begin
      ref_mem[scrub_pos] = '0;
      scrub_pos++;
      done_m = (scrub_pos == DEPTH);
      if (done_m) scrub_pos = -1;
    end else begin
      if (bus_a.wr0_en) ref_mem[bus_a.wr0_addr] = bus_a.wr0_data;
      if (bus_a.wr1_en) ref_mem[bus_a.wr1_addr] = bus_a.wr1_data;
      done_m = 1'b0;
      if (start) scrub_pos = 0;
    end
  endtask

  task automatic expect_now(input string name);
    for (int p = 0; p < NR; p++) begin
      int a;
      a = int'(bus_a.rd_addr[p*AW +: AW]);
      sb.push_back('{name: $sformatf("%s.z1_rd%0d", name, p), sig: 0, port: p, exp: exp_read(a, 1'b1)});
      sb.push_back('{name: $sformatf("%s.z0_rd%0d", name, p), sig: 1, port: p, exp: exp_read(a, 1'b0)});
    end
    sb.push_back('{name: {name, ".z1_busy"}, sig: 2, port: 0, exp: {31'b0, scrub_pos >= 0}});
    sb.push_back('{name: {name, ".z1_done"}, sig: 3, port: 0, exp: {31'b0, done_m}});
    sb.push_back('{name: {name, ".z0_busy"}, sig: 4, port: 0, exp: {31'b0, scrub_pos >= 0}});
    sb.push_back('{name: {name, ".z0_done"}, sig: 5, port: 0, exp: {31'b0, done_m}});
    chk_vld = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic drive(input string name,
                       input bit w0e, input int w0a, input logic [31:0] w0d,
                       input bit w1e, input int w1a, input logic [31:0] w1d,
                       input bit cs, input int r0, input int r1, input int r2);
    bus_a.wr0_en    = w0e;
    bus_a.wr0_addr  = AW'(w0a);
    bus_a.wr0_data  = w0d;
    bus_a.wr1_en    = w1e;
    bus_a.wr1_addr  = AW'(w1a);
    bus_a.wr1_data  = w1d;
    bus_a.clr_start = cs;
    bus_a.rd_addr   = {AW'(r2), AW'(r1), AW'(r0)};
    expect_now(name);
    step();
  endtask

  task automatic read3(input string name, input int r0, input int r1, input int r2);
    drive(name, 0, 0, 0, 0, 0, 0, 0, r0, r1, r2);
  endtask

  // Assert rst partway through a cycle, before any edge, and check its effect before the next edge.
  task automatic rst_mid(input string name, input int r0, input int r1, input int r2);
    bus_a.wr0_en    = 1'b0;
    bus_a.wr1_en    = 1'b0;
    bus_a.clr_start = 1'b0;
    bus_a.rd_addr   = {AW'(r2), AW'(r1), AW'(r0)};
    #1;
    rst = 1'b1;
    model_reset();
    expect_now(name);
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic drain_scrub();
    for (int k = 0; k < DEPTH + 3 && (scrub_pos >= 0 || done_m); k++)
      read3("drain", k % DEPTH, 31, 0);
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      while (sb.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sig)
          0:       act = bus_a.rd_data[e.port*DW +: DW];
          1:       act = bus_b.rd_data[e.port*DW +: DW];
          2:       act = {31'b0, bus_a.clr_busy};
          3:       act = {31'b0, bus_a.clr_done};
          4:       act = {31'b0, bus_b.clr_busy};
          default: act = {31'b0, bus_b.clr_done};
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_a.wr0_en = 0; bus_a.wr0_addr = 0; bus_a.wr0_data = 0;
    bus_a.wr1_en = 0; bus_a.wr1_addr = 0; bus_a.wr1_data = 0;
    bus_a.clr_start = 0; bus_a.rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    read3("reset_state", 0, 1, 31);

    // Async reset wipes a freshly written entry within the same cycle.
    drive("wr_r5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0, 1);
    read3("r5_written", 5, 5, 5);
    rst_mid("rst_async", 5, 5, 5);
    read3("after_rst", 5, 0, 31);

    drive("dual_wr_r7", 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 7, 7, 7);
    read3("r7_port1_wins", 7, 7, 7);

    drive("wr_r0", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
    read3("r0_zero_reg", 0, 0, 0);

    drive("wr_r9_old", 1, 9, 32'h00000099, 0, 0, 0, 0, 9, 9, 9);
    drive("r9_same_cycle", 0, 0, 0, 1, 9, 32'hCAFE0001, 0, 0, 1, 9);
    read3("r9_next_cycle", 9, 9, 9);

    for (int n = 0; n < 300; n++)
      drive("rand", $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom,
            $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom,
            ($urandom_range(0, 49) == 0),
            $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
    drain_scrub();

    // Full scrub: fill, start with a same-edge write, interfere mid-scrub, then sweep.
    for (int i = 1; i < DEPTH; i++) drive("fill", 1, i, i, 0, 0, 0, 0, i, 0, 31);
    drive("start_with_wr", 1, 2, 32'h0000AAAA, 0, 0, 0, 1, 2, 1, 31);
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k == 5)
        drive("scrub_wr_lost", 1, 31, 32'h55555555, 1, 30, 32'h66666666, 0, 31, 30, 2);
      else
        drive("scrub", 0, 0, 0, 0, 0, 0, (k == 3), k % DEPTH, (k + 1) % DEPTH, 31);
    end
    for (int j = 0; j < 11; j++) read3("post_scrub", 3 * j, (3 * j + 1) % DEPTH, (3 * j + 2) % DEPTH);

    // Reset during scrub: no done pulse, array cleared, next scrub restarts at entry 0.
    for (int i = 0; i < DEPTH; i += 3) drive("fill2", 1, i, 32'h100 + i, 1, DEPTH - 1 - i, 32'h200 + i, 0, i, 1, 31);
    drive("start2", 0, 0, 0, 0, 0, 0, 1, 0, 1, 31);
    for (int k = 0; k < 10; k++) read3("scrub2", k, k + 1, 31);
    rst_mid("rst_mid_scrub", 10, 20, 31);
    for (int k = 0; k < 3; k++) read3("no_done", 0, 15, 31);
    drive("wr_r1", 1, 1, 32'h5, 1, 31, 32'h7, 0, 0, 1, 31);
    drive("wr_r0b", 1, 0, 32'h3, 0, 0, 0, 0, 0, 1, 31);
    drive("restart", 0, 0, 0, 0, 0, 0, 1, 0, 1, 31);
    for (int k = 0; k < 4; k++) read3("restart_scrub", 0, 1, 31);
    drain_scrub();
    read3("final", 0, 1, 31);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
